// File: rtl/lenet_accu_pkg.sv
// Shared definitions for the LeNet5 channel accumulator: FP32 constants and
// helpers that size the pixel and channel counters.
package lenet_accu_pkg;

    localparam logic [31:0] FP_ZERO     = 32'h0000_0000;
    localparam logic [31:0] FP_SIGN_BIT = 32'h8000_0000;
    localparam logic [31:0] FP_QNAN     = 32'h7FC0_0000;

    // Pixel address width; a single-pixel map still needs one bit.
    function automatic int addr_bits(input int n_pixels);
        return (n_pixels <= 1) ? 1 : $clog2(n_pixels);
    endfunction

    // Channel counter width, one bit wider than the index range.
    function automatic int ch_bits(input int n_channels);
        return $clog2(n_channels) + 1;
    endfunction

endpackage

// File: rtl/FP_Adder.sv
// Combinational IEEE-754 single-precision adder, round-to-nearest-even.
// Denormal inputs and outputs are handled; NaN results are the canonical qNaN.
module FP_Adder
    import lenet_accu_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_sum
);

    logic        w_a_big;
    logic [31:0] w_big, w_sml;
    logic [7:0]  w_ex_big, w_ex_sml;
    logic [23:0] w_m_big, w_m_sml;
    logic [49:0] w_sh;
    logic [26:0] w_mb, w_ms, w_norm;
    logic [27:0] w_sum;
    logic [24:0] w_rnd;
    int          w_d;
    int          w_exp;

    // Align, add/subtract, normalise and round.
    always_comb begin
        w_a_big  = (i_a[30:0] >= i_b[30:0]);
        w_big    = w_a_big ? i_a : i_b;
        w_sml    = w_a_big ? i_b : i_a;
        w_m_big  = {|w_big[30:23], w_big[22:0]};
        w_m_sml  = {|w_sml[30:23], w_sml[22:0]};
        w_ex_big = (w_big[30:23] == 8'd0) ? 8'd1 : w_big[30:23];
        w_ex_sml = (w_sml[30:23] == 8'd0) ? 8'd1 : w_sml[30:23];
        w_d      = int'(w_ex_big) - int'(w_ex_sml);
        w_sh     = {w_m_sml, 26'b0} >> ((w_d > 31) ? 31 : w_d);
        w_ms     = {w_sh[49:24], |w_sh[23:0]};
        w_mb     = {w_m_big, 3'b000};
        w_sum    = (w_big[31] == w_sml[31]) ? ({1'b0, w_mb} + {1'b0, w_ms})
                                            : ({1'b0, w_mb} - {1'b0, w_ms});
        w_exp    = int'(w_ex_big);
        w_norm   = w_sum[26:0];
        w_rnd    = 25'd0;
        o_sum    = FP_ZERO;

        if (&w_big[30:23]) begin
            if ((w_big[22:0] != 23'd0) || ((&w_sml[30:23]) && (w_big[31] != w_sml[31])))
                o_sum = FP_QNAN;
            else
                o_sum = w_big;
        end else if (w_sum == 28'd0) begin
            o_sum = {w_big[31] & w_sml[31], 31'b0};
        end else begin
            if (w_sum[27]) begin
                w_norm = {w_sum[27:2], w_sum[1] | w_sum[0]};
                w_exp  = w_exp + 1;
            end else begin
                // Left shifts only follow near-cancellation, where no sticky bits exist.
                for (int k = 0; k < 26; k++) begin
                    if (!w_norm[26] && (w_exp > 1)) begin
                        w_norm = w_norm << 1;
                        w_exp  = w_exp - 1;
                    end
                end
            end
            w_rnd = {1'b0, w_norm[26:3]}
                  + 25'(w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]));
            if (w_rnd[24]) begin
                w_rnd = w_rnd >> 1;
                w_exp = w_exp + 1;
            end
            if (w_exp >= 255)
                o_sum = {w_big[31], 8'hFF, 23'b0};
            else if (!w_rnd[23])
                o_sum = {w_big[31], 8'h00, w_rnd[22:0]};
            else
                o_sum = {w_big[31], 8'(w_exp), w_rnd[22:0]};
        end
    end

endmodule

// File: rtl/channel_accumulator_psum_buffer.sv
// Per-pixel partial-sum store: synchronous write, combinational read, so a
// value written at one edge is visible to the very next access.
module psum_buffer #(
    parameter int DATA_WIDTH       = 32,
    parameter int NUMBER_OF_PIXELS = 100,
    parameter int ADDR_W           = 7
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_W-1:0]     i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_W-1:0]     i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [NUMBER_OF_PIXELS];

    // Storage is never cleared; channel 0 always overwrites every entry.
    always_ff @(posedge clk) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/channel_accumulator.sv
// Multi-channel partial-sum accumulator for the LeNet5 convolution datapath.
// Inputs arrive channel-major; channel 0 is seeded with the bias, the last
// channel pass emits each finished pixel with its address one cycle later.
// Optional macro CHANNEL_ACCUMULATOR_RELU_EN clamps negative outputs to +0.
module channel_accumulator
    import lenet_accu_pkg::*;
#(
    parameter int DATA_WIDTH              = 32,
    parameter int IFM_SIZE_NEXT           = 10,
    parameter int NUMBER_OF_CHANNELS      = 6,
    parameter int NUMBER_OF_PIXELS        = IFM_SIZE_NEXT * IFM_SIZE_NEXT,
    parameter int ADDRESS_SIZE_NEXT_IFM   = addr_bits(NUMBER_OF_PIXELS),
    parameter int NUMBER_OF_BITS_CHANNELS = ch_bits(NUMBER_OF_CHANNELS)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    input  logic [DATA_WIDTH-1:0]            data_in_from_conv,
    input  logic [DATA_WIDTH-1:0]            data_bias,
    output logic                             out_valid,
    output logic [DATA_WIDTH-1:0]            accu_data_out,
    output logic [ADDRESS_SIZE_NEXT_IFM-1:0] out_addr,
    output logic                             done,
    output logic                             busy
);

    logic [ADDRESS_SIZE_NEXT_IFM-1:0]   r_pix_cnt;
    logic [NUMBER_OF_BITS_CHANNELS-1:0] r_ch_cnt;
    logic                               r_out_valid, r_done, r_busy;
    logic [DATA_WIDTH-1:0]              r_data_out;
    logic [ADDRESS_SIZE_NEXT_IFM-1:0]   r_out_addr;

    logic                  w_first_ch, w_last_ch, w_last_pix;
    logic [DATA_WIDTH-1:0] w_psum_rd, w_addend, w_sum, w_result;

    assign w_first_ch = (r_ch_cnt == '0);
    assign w_last_ch  = (r_ch_cnt == NUMBER_OF_BITS_CHANNELS'(NUMBER_OF_CHANNELS - 1));
    assign w_last_pix = (r_pix_cnt == ADDRESS_SIZE_NEXT_IFM'(NUMBER_OF_PIXELS - 1));

    psum_buffer #(
        .DATA_WIDTH       (DATA_WIDTH),
        .NUMBER_OF_PIXELS (NUMBER_OF_PIXELS),
        .ADDR_W           (ADDRESS_SIZE_NEXT_IFM)
    ) u_psum (
        .clk     (clk),
        .i_we    (in_valid && !w_last_ch && !rst),
        .i_waddr (r_pix_cnt),
        .i_wdata (w_sum),
        .i_raddr (r_pix_cnt),
        .o_rdata (w_psum_rd)
    );

    assign w_addend = w_first_ch ? data_bias : w_psum_rd;

    FP_Adder u_add (
        .i_a   (data_in_from_conv),
        .i_b   (w_addend),
        .o_sum (w_sum)
    );

`ifdef CHANNEL_ACCUMULATOR_RELU_EN
    assign w_result = ((w_sum & FP_SIGN_BIT) != FP_ZERO) ? FP_ZERO : w_sum;
`else
    assign w_result = w_sum;
`endif

    // Counters, output register and status flags; reset beats a coincident input.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pix_cnt   <= '0;
            r_ch_cnt    <= '0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
            r_data_out  <= '0;
            r_out_addr  <= '0;
        end else begin
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            if (in_valid) begin
                r_busy <= 1'b1;
                if (w_last_ch) begin
                    r_data_out  <= w_result;
                    r_out_addr  <= r_pix_cnt;
                    r_out_valid <= 1'b1;
                end
                if (w_last_pix) begin
                    r_pix_cnt <= '0;
                    if (w_last_ch) begin
                        r_ch_cnt <= '0;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                    end else begin
                        r_ch_cnt <= r_ch_cnt + 1'b1;
                    end
                end else begin
                    r_pix_cnt <= r_pix_cnt + 1'b1;
                end
            end
        end
    end

    assign out_valid     = r_out_valid;
    assign done          = r_done;
    assign busy          = r_busy;
    assign accu_data_out = r_data_out;
    assign out_addr      = r_out_addr;

endmodule

// File: doc/channel_accumulator.md
# channel_accumulator

Sequential, parametrised multi-channel partial-sum accumulator for the LeNet5 convolution datapath. It sits between a convolution unit and the next-layer IFM memory. It consumes one FP32 convolution result per valid cycle, streamed channel-major (all output pixels of channel 0, then channel 1, and so on). It keeps per-pixel partial sums in an internal buffer, seeds each sum with the filter bias on the first channel, and emits the finished pixel, with its address, during the last channel pass.

## Interface
- `DATA_WIDTH`, 32, IEEE-754 single word width
- `IFM_SIZE_NEXT`, 10, output feature-map side length
- `NUMBER_OF_CHANNELS`, 6, input channels summed per output pixel (≥1)
- `NUMBER_OF_PIXELS`, `IFM_SIZE_NEXT*IFM_SIZE_NEXT`, derived
- `ADDRESS_SIZE_NEXT_IFM`, `$clog2(NUMBER_OF_PIXELS)`, derived, min 1
- `NUMBER_OF_BITS_CHANNELS`, `$clog2(NUMBER_OF_CHANNELS)+1`, derived

- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  `data_in_from_conv` valid this cycle
- `data_in_from_conv`  in  DATA_WIDTH  convolution result for current (channel, pixel)
- `data_bias`  in  DATA_WIDTH  filter bias, stable for the whole filter
- `out_valid`  out  1  one-cycle pulse, finished pixel on `accu_data_out`
- `accu_data_out`  out  DATA_WIDTH  finished pixel value
- `out_addr`  out  ADDRESS_SIZE_NEXT_IFM  pixel index of `accu_data_out`
- `done`  out  1  one-cycle pulse coincident with the last pixel's `out_valid`
- `busy`  out  1  high from the first accepted input until `done`

## Operation
- Two counters:
  - `pix_cnt` counts 0..NUMBER_OF_PIXELS-1.
  - `ch_cnt` counts 0..NUMBER_OF_CHANNELS-1.
- Both advance only on `in_valid`.
- When `pix_cnt` wraps, `ch_cnt` increments.
- Addend mux: `ch_cnt==0` selects `data_bias`; otherwise it selects `psum[pix_cnt]`.
- Sum = `FP_Adder(data_in_from_conv, addend)`, computed combinationally.
- On `in_valid` with `ch_cnt<NUMBER_OF_CHANNELS-1`: sum is written to `psum[pix_cnt]`; no output.
- On `in_valid` with `ch_cnt==NUMBER_OF_CHANNELS-1`:
  - Sum is registered to `accu_data_out`, `pix_cnt` to `out_addr`, and `out_valid` is set.
  - `psum` is not written.
- Last input (last channel, last pixel): `done` is set with `out_valid`, both counters return to 0, and `busy` clears.
- `in_valid` low: counters, buffer and `busy` hold; `out_valid`/`done` are 0 next cycle.
- No back-pressure. The downstream must accept every `out_valid` pulse.
- `NUMBER_OF_CHANNELS==1`: every input emits `data_in+bias` directly, and the buffer is unused.
- `IFM_SIZE_NEXT==1`: consecutive inputs hit the same address. Write-before-read ordering guarantees the updated value is used (see Timing).

## Timing
- Latency 1: `out_valid` is high in cycle t+1 for an input accepted at edge t.
- Throughput: one input per cycle, with gaps allowed anywhere.
- `psum` is written at the accepting edge and read combinationally, so back-to-back same-address accesses are hazard-free.
- Reset values:
  - `out_valid`, `done`, `busy`, `accu_data_out`, `out_addr` = 0.
  - Counters = 0.
  - `psum` is not cleared; channel 0 always overwrites it.
- Reset mid-filter: the next input is treated as channel 0, pixel 0. Stale `psum` is irrelevant.
- `rst` and `in_valid` asserted together: reset wins and the input is dropped.

## Configuration
- `CHANNEL_ACCUMULATOR_RELU_EN` defined: ReLU on the output path. If the sign bit of the final sum is 1, `accu_data_out` = 0x00000000 (this also turns -0 into +0). Partial sums are unaffected.
- `CHANNEL_ACCUMULATOR_RELU_EN` undefined: raw sum is output.

## Structure
- Shared package `lenet_accu_pkg`:
  - FP32 constants `FP_ZERO`, `FP_SIGN_BIT`
  - counter width helper functions
- Sub-modules:
  - Existing `FP_Adder` is reused for the sum.
  - One new sub-module, `psum_buffer`: NUMBER_OF_PIXELS x DATA_WIDTH register array, synchronous write, combinational read.

## Test plan
- CH=3, SIZE=2:
  - Stimulus: conv 1.0 (0x3F800000) on all 12 inputs, bias 0.5 (0x3F000000).
  - Response: four `out_valid` pulses in cycles 10..13 with 0x40600000 at addr 0..3; `done` with addr 3; none earlier.
- Same stimulus with random `in_valid` gaps → identical values and addresses; `busy` high throughout.
- ReLU case, CH=3, bias -4.0 (0xC0800000), conv 1.0: output 0x00000000 with macro, 0xBF800000 without.
- `rst` asserted after 5 inputs, then 12 clean inputs → results as in the first scenario; no output from the aborted pass.
- CH=1, SIZE=1: conv 2.0 (0x40000000), bias 0.5 → 0x40200000 with `out_valid` and `done` every accepted cycle.
- CH=4, SIZE=1: back-to-back conv 1.0, bias 0 → 0x40800000 after the 4th input (same-address hazard check).
